psr_flags: RTL and testbench

//  Processor Status Register stage directly downstream of the ALU. Latches the ALU flag outputs
//  (carry, low, overflow, negative, zero) under per-flag write masks from the decoder. Feeds the

---
 rtl/psr_flags.sv | 118 +++++++++++
 tb/tb_psr_flags.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psr_flags.sv
// Processor Status Register stage behind the ALU: masked flag capture, LPR/SPR access,
// one-level interrupt shadow and branch-condition evaluation against the stored flags.
module psr_flags #(
    parameter int         WIDTH_PSR   = 16,
    parameter int         WIDTH_COND  = 4,
    parameter logic [4:0] RESET_FLAGS = 5'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  carry_in,
    input  logic                  low_in,
    input  logic                  over_in,
    input  logic                  neg_in,
    input  logic                  zero_in,
    input  logic [4:0]            flag_we,
    input  logic [WIDTH_COND-1:0] cond,
    input  logic                  psr_wr_en,
    input  logic [WIDTH_PSR-1:0]  psr_wr_data,
    input  logic                  save_en,
    input  logic                  restore_en,
    output logic                  carry_to_alu,
    output logic                  cond_true,
    output logic [4:0]            flags,
    output logic [WIDTH_PSR-1:0]  psr_rd_data
);

    // Flag positions inside the {C,L,F,N,Z} vector.
    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    // Flag positions inside the software-visible PSR word.
    localparam int PSR_C = 0;
    localparam int PSR_L = 2;
    localparam int PSR_F = 5;
    localparam int PSR_Z = 6;
    localparam int PSR_N = 7;

    logic [4:0] flags_q;
    logic [4:0] flags_d;
    logic [4:0] shadow_q;
    logic [4:0] shadow_d;
    logic [4:0] alu_flags;
    logic [4:0] lpr_flags;

    always_comb begin
        alu_flags = {carry_in, low_in, over_in, neg_in, zero_in};
        lpr_flags = {psr_wr_data[PSR_C], psr_wr_data[PSR_L], psr_wr_data[PSR_F],
                     psr_wr_data[PSR_N], psr_wr_data[PSR_Z]};
    end

    // Priority restore > LPR > masked ALU update; save always captures the pre-edge flags,
    // so save together with restore swaps the two copies.
    always_comb begin
        flags_d  = flags_q;
        shadow_d = shadow_q;
        if (en) begin
            if (restore_en) begin
                flags_d = shadow_q;
            end else if (psr_wr_en) begin
                flags_d = lpr_flags;
            end else begin
                flags_d = (flags_q & ~flag_we) | (alu_flags & flag_we);
            end
            if (save_en) begin
                shadow_d = flags_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q  <= RESET_FLAGS;
            shadow_q <= RESET_FLAGS;
        end else begin
            flags_q  <= flags_d;
            shadow_q <= shadow_d;
        end
    end

    assign flags        = flags_q;
    assign carry_to_alu = flags_q[FLAG_C];

    always_comb begin
        psr_rd_data        = '0;
        psr_rd_data[PSR_C] = flags_q[FLAG_C];
        psr_rd_data[PSR_L] = flags_q[FLAG_L];
        psr_rd_data[PSR_F] = flags_q[FLAG_F];
        psr_rd_data[PSR_Z] = flags_q[FLAG_Z];
        psr_rd_data[PSR_N] = flags_q[FLAG_N];
    end

    always_comb begin
        cond_true = 1'b0;
        case (cond[3:0])
            4'b0000: cond_true = flags_q[FLAG_Z];
            4'b0001: cond_true = !flags_q[FLAG_Z];
            4'b0010: cond_true = flags_q[FLAG_C];
            4'b0011: cond_true = !flags_q[FLAG_C];
            4'b0100: cond_true = flags_q[FLAG_L];
            4'b0101: cond_true = !flags_q[FLAG_L];
            4'b0110: cond_true = flags_q[FLAG_N];
            4'b0111: cond_true = !flags_q[FLAG_N];
            4'b1000: cond_true = flags_q[FLAG_F];
            4'b1001: cond_true = !flags_q[FLAG_F];
            4'b1010: cond_true = !flags_q[FLAG_L] && !flags_q[FLAG_Z];
            4'b1011: cond_true = flags_q[FLAG_L] || flags_q[FLAG_Z];
            4'b1100: cond_true = !flags_q[FLAG_N] && !flags_q[FLAG_Z];
            4'b1101: cond_true = flags_q[FLAG_N] || flags_q[FLAG_Z];
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_psr_flags.sv
// Directed and randomized bench for psr_flags against a named-flag reference model.
module tb_psr_flags;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b1;
    logic        carry_in = 1'b0;
    logic        low_in = 1'b0;
    logic        over_in = 1'b0;
    logic        neg_in = 1'b0;
    logic        zero_in = 1'b0;
    logic [4:0]  flag_we = 5'b0;
    logic [3:0]  cond = 4'b0;
    logic        psr_wr_en = 1'b0;
    logic [15:0] psr_wr_data = 16'h0;
    logic        save_en = 1'b0;
    logic        restore_en = 1'b0;
    logic        carry_to_alu;
    logic        cond_true;
    logic [4:0]  flags;
    logic [15:0] psr_rd_data;

    int checks = 0;
    int failures = 0;

    // Reference model: named flags of the architectural and shadow copies.
    typedef struct {
        bit c, l, f, n, z;
    } flag_set_t;

    flag_set_t m_cur;
    flag_set_t m_sh;

    psr_flags dut (
        .clk(clk), .reset_n(reset_n), .en(en),
        .carry_in(carry_in), .low_in(low_in), .over_in(over_in), .neg_in(neg_in),
        .zero_in(zero_in), .flag_we(flag_we), .cond(cond), .psr_wr_en(psr_wr_en),
        .psr_wr_data(psr_wr_data), .save_en(save_en), .restore_en(restore_en),
        .carry_to_alu(carry_to_alu), .cond_true(cond_true), .flags(flags),
        .psr_rd_data(psr_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] pack5(input flag_set_t s);
        return {s.c, s.l, s.f, s.n, s.z};
    endfunction

    function automatic int psr_word(input flag_set_t s);
        return int'(s.c) * 1 + int'(s.l) * 4 + int'(s.f) * 32 + int'(s.z) * 64 + int'(s.n) * 128;
    endfunction

    function automatic bit exp_cond(input int cc, input flag_set_t s);
        bit base;
        if (cc < 10) begin
            // Even codes test a flag, the following odd code tests its complement.
            case (cc / 2)
                0: base = s.z;
                1: base = s.c;
                2: base = s.l;
                3: base = s.n;
                default: base = s.f;
            endcase
            return (cc % 2 == 1) ? !base : base;
        end
        if (cc == 10) return !(s.l || s.z);
        if (cc == 11) return s.l || s.z;
        if (cc == 12) return !(s.n || s.z);
        if (cc == 13) return s.n || s.z;
        return cc == 14;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cur = '{0, 0, 0, 0, 0};
        m_sh  = '{0, 0, 0, 0, 0};
    endtask

    // Apply one clock edge to the model using the currently driven inputs.
    task automatic model_edge();
        flag_set_t old;
        flag_set_t nxt;
        old = m_cur;
        nxt = m_cur;
        if (en) begin
            if (restore_en) begin
                nxt = m_sh;
            end else if (psr_wr_en) begin
                nxt.c = psr_wr_data[0];
                nxt.l = psr_wr_data[2];
                nxt.f = psr_wr_data[5];
                nxt.z = psr_wr_data[6];
                nxt.n = psr_wr_data[7];
            end else begin
                if (flag_we[4]) nxt.c = carry_in;
                if (flag_we[3]) nxt.l = low_in;
                if (flag_we[2]) nxt.f = over_in;
                if (flag_we[1]) nxt.n = neg_in;
                if (flag_we[0]) nxt.z = zero_in;
            end
            if (save_en) m_sh = old;
            m_cur = nxt;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b1; flag_we = 5'b0; psr_wr_en = 1'b0; psr_wr_data = 16'h0;
        save_en = 1'b0; restore_en = 1'b0;
        {carry_in, low_in, over_in, neg_in, zero_in} = 5'b0;
    endtask

    task automatic set_alu(input logic [4:0] v);
        {carry_in, low_in, over_in, neg_in, zero_in} = v;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".flags"}, {11'b0, flags}, {11'b0, pack5(m_cur)});
        check({tag, ".carry"}, {15'b0, carry_to_alu}, {15'b0, m_cur.c});
        check({tag, ".psr"}, psr_rd_data, 16'(psr_word(m_cur)));
    endtask

    initial begin
        model_reset();
        idle();
        // Reset state at time zero.
        #2;
        check("reset.flags", {11'b0, flags}, 16'h0);
        check("reset.carry", {15'b0, carry_to_alu}, 16'h0);
        check("reset.psr", psr_rd_data, 16'h0);
        cond = 4'b1110; #1;
        check("reset.uc", {15'b0, cond_true}, 16'h1);
        cond = 4'b1111; #1;
        check("reset.never", {15'b0, cond_true}, 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Masked update.
        set_alu(5'b11111); flag_we = 5'b10001;
        tick();
        check("masked.flags", {11'b0, flags}, 16'h0011);
        check("masked.carry", {15'b0, carry_to_alu}, 16'h1);
        check("masked.psr", psr_rd_data, 16'h0041);
        idle();

        // Asynchronous reset mid-cycle after flags became non-zero.
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_state("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        set_alu(5'b01010); flag_we = 5'b11111;
        tick();
        check_state("post_reset_edge");
        idle();

        // Condition sweep over all flag combinations.
        for (int fv = 0; fv < 32; fv++) begin
            logic [4:0] f5;
            f5 = 5'(fv);
            psr_wr_en = 1'b1;
            psr_wr_data = 16'($urandom) & 16'hFF1A;
            psr_wr_data[0] = f5[4];
            psr_wr_data[2] = f5[3];
            psr_wr_data[5] = f5[2];
            psr_wr_data[7] = f5[1];
            psr_wr_data[6] = f5[0];
            flag_we = 5'($urandom);
            set_alu(5'($urandom));
            tick();
            idle();
            check_state("sweep");
            for (int cc = 0; cc < 16; cc++) begin
                cond = 4'(cc); #1;
                check($sformatf("cond%0d_f%0d", cc, fv), {15'b0, cond_true},
                      {15'b0, exp_cond(cc, m_cur)});
            end
        end

        // Stall: load a known shadow, change flags, then stall with everything asserted.
        set_alu(5'b00110); flag_we = 5'b11111; tick();
        idle(); save_en = 1'b1; tick();
        idle(); set_alu(5'b11001); flag_we = 5'b11111; tick();
        en = 1'b0; flag_we = 5'b11111; psr_wr_en = 1'b1; psr_wr_data = 16'hFFFF;
        restore_en = 1'b1; save_en = 1'b1; set_alu(5'b00000);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall.flags", {11'b0, flags}, 16'h0019);
        end
        en = 1'b1; save_en = 1'b0;
        tick();
        check("stall.release", {11'b0, flags}, 16'h0006);
        idle();

        // Save/restore and swap.
        set_alu(5'b10100); flag_we = 5'b11111; tick();
        idle(); save_en = 1'b1; tick();
        idle(); set_alu(5'b01011); flag_we = 5'b11111; tick();
        check("sr.updated", {11'b0, flags}, 16'h000B);
        idle(); restore_en = 1'b1; flag_we = 5'b11111; set_alu(5'b01111); tick();
        check("sr.restore_wins", {11'b0, flags}, 16'h0014);
        idle(); set_alu(5'b01011); flag_we = 5'b11111; tick();
        idle(); save_en = 1'b1; restore_en = 1'b1; tick();
        check("sr.swap_flags", {11'b0, flags}, 16'h0014);
        idle(); restore_en = 1'b1; tick();
        check("sr.swap_shadow", {11'b0, flags}, 16'h000B);
        idle();

        // LPR beats ALU update.
        psr_wr_en = 1'b1; psr_wr_data = 16'hFFFF; flag_we = 5'b11111; set_alu(5'b0);
        tick();
        check("lpr.flags", {11'b0, flags}, 16'h001F);
        check("lpr.psr", psr_rd_data, 16'h00E5);
        idle();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            en          = ($urandom_range(0, 7) != 0);
            flag_we     = 5'($urandom);
            set_alu(5'($urandom));
            psr_wr_en   = ($urandom_range(0, 5) == 0);
            psr_wr_data = 16'($urandom);
            save_en     = ($urandom_range(0, 4) == 0);
            restore_en  = ($urandom_range(0, 5) == 0);
            tick();
            check_state("rand");
            cond = 4'($urandom_range(0, 15)); #1;
            check("rand.cond", {15'b0, cond_true}, {15'b0, exp_cond(int'(cond), m_cur)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
